// File: rtl/tek_port_ram_denetleyici.sv
// Single-port RAM bus master: turns a valid/ready request stream into timed RAM cycles.
// Optional power-up zero sweep of the RAM is enabled with `define RAM_TEMIZLE_EN.
//
// state   | meaning
// BOS     | idle, ready for a request (unless a sweep is still pending)
// YAZ     | write strobe cycle, controller drives veri
// OKU_1   | chip enabled, RAM loads its output register
// OKU_2   | RAM drives veri, data captured at end of cycle
// DONUS   | bus turnaround, read data valid pulse
// HATA    | out-of-range address pulse, no bus activity
// TEMIZLE | zero sweep of all rows (RAM_TEMIZLE_EN only)
module tek_port_ram_denetleyici #(
  parameter int adres_genisligi = 4,
  parameter int veri_obegi      = 16,
  parameter int satir_sayisi    = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       istek_gecerli_i,
  output logic                       istek_hazir_o,
  input  logic                       istek_yaz_i,
  input  logic [adres_genisligi-1:0] istek_adres_i,
  input  logic [veri_obegi-1:0]      istek_veri_i,
  output logic                       yanit_gecerli_o,
  output logic [veri_obegi-1:0]      yanit_veri_o,
  output logic                       adres_hatasi_o,
  output logic [adres_genisligi-1:0] adres_o,
  inout  wire  [veri_obegi-1:0]      veri_io,
  output logic                       cip_aktif_o,
  output logic                       bellege_yaz_o,
  output logic                       bellekten_oku_o
);

  typedef enum logic [2:0] {
    BOS, YAZ, OKU_1, OKU_2, DONUS, HATA
`ifdef RAM_TEMIZLE_EN
    , TEMIZLE
`endif
  } durum_t;

  // One extra bit so that satir_sayisi == 2**adres_genisligi makes every address legal.
  localparam logic [adres_genisligi:0] SATIR_SINIRI = (adres_genisligi+1)'(satir_sayisi);

  durum_t                     durum_q, durum_d;
  logic [adres_genisligi-1:0] adres_q, adres_d;
  logic [veri_obegi-1:0]      yazma_q, yazma_d;
  logic [veri_obegi-1:0]      yanit_veri_q;
  logic                       cip_q, cip_d;
  logic                       yaz_q, yaz_d;
  logic                       oku_q, oku_d;
  logic                       veri_sur_q, veri_sur_d;
  logic                       yanit_gecerli_q, yanit_gecerli_d;
  logic                       hata_q, hata_d;
  logic                       kabul;
  logic                       adres_yasal;

`ifdef RAM_TEMIZLE_EN
  localparam logic [adres_genisligi-1:0] SON_SATIR = adres_genisligi'(satir_sayisi - 1);
  logic [adres_genisligi-1:0] sayac_q, sayac_d;
  logic                       temiz_bekle_q, temiz_bekle_d;

  assign istek_hazir_o = (durum_q == BOS) && !rst_i && !temiz_bekle_q;
`else
  assign istek_hazir_o = (durum_q == BOS) && !rst_i;
`endif

  assign kabul       = istek_gecerli_i && istek_hazir_o;
  assign adres_yasal = {1'b0, istek_adres_i} < SATIR_SINIRI;

  always_comb begin
    durum_d = durum_q;
    adres_d = adres_q;
    yazma_d = yazma_q;
`ifdef RAM_TEMIZLE_EN
    sayac_d       = sayac_q;
    temiz_bekle_d = temiz_bekle_q;
`endif
    unique case (durum_q)
      BOS: begin
`ifdef RAM_TEMIZLE_EN
        if (temiz_bekle_q) begin
          durum_d       = TEMIZLE;
          temiz_bekle_d = 1'b0;
          sayac_d       = '0;
          adres_d       = '0;
          yazma_d       = '0;
        end else
`endif
        if (kabul) begin
          if (!adres_yasal) begin
            durum_d = HATA;
          end else begin
            adres_d = istek_adres_i;
            durum_d = istek_yaz_i ? YAZ : OKU_1;
            if (istek_yaz_i) yazma_d = istek_veri_i;
          end
        end
      end
      YAZ:   durum_d = BOS;
      OKU_1: durum_d = OKU_2;
      OKU_2: durum_d = DONUS;
      DONUS: durum_d = BOS;
      HATA:  durum_d = BOS;
`ifdef RAM_TEMIZLE_EN
      TEMIZLE: begin
        if (sayac_q == SON_SATIR) begin
          durum_d = BOS;
        end else begin
          sayac_d = sayac_q + 1'b1;
          adres_d = sayac_q + 1'b1;
        end
      end
`endif
      default: durum_d = BOS;
    endcase

    // Strobes are registered from the state being entered, so they line up with it.
    cip_d           = (durum_d == YAZ) || (durum_d == OKU_1) || (durum_d == OKU_2);
    yaz_d           = (durum_d == YAZ);
    oku_d           = (durum_d == OKU_2);
    veri_sur_d      = (durum_d == YAZ);
    yanit_gecerli_d = (durum_d == DONUS);
    hata_d          = (durum_d == HATA);
`ifdef RAM_TEMIZLE_EN
    if (durum_d == TEMIZLE) begin
      cip_d      = 1'b1;
      yaz_d      = 1'b1;
      veri_sur_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q         <= BOS;
      adres_q         <= '0;
      yazma_q         <= '0;
      yanit_veri_q    <= '0;
      cip_q           <= 1'b0;
      yaz_q           <= 1'b0;
      oku_q           <= 1'b0;
      veri_sur_q      <= 1'b0;
      yanit_gecerli_q <= 1'b0;
      hata_q          <= 1'b0;
`ifdef RAM_TEMIZLE_EN
      sayac_q         <= '0;
      temiz_bekle_q   <= 1'b1;
`endif
    end else begin
      durum_q         <= durum_d;
      adres_q         <= adres_d;
      yazma_q         <= yazma_d;
      cip_q           <= cip_d;
      yaz_q           <= yaz_d;
      oku_q           <= oku_d;
      veri_sur_q      <= veri_sur_d;
      yanit_gecerli_q <= yanit_gecerli_d;
      hata_q          <= hata_d;
      if (durum_q == OKU_2) yanit_veri_q <= veri_io;
`ifdef RAM_TEMIZLE_EN
      sayac_q         <= sayac_d;
      temiz_bekle_q   <= temiz_bekle_d;
`endif
    end
  end

  // Released in DONUS, so a write after a read never overlaps the RAM's drive.
  assign veri_io = veri_sur_q ? yazma_q : {veri_obegi{1'bz}};

  assign adres_o         = adres_q;
  assign cip_aktif_o     = cip_q;
  assign bellege_yaz_o   = yaz_q;
  assign bellekten_oku_o = oku_q;
  assign yanit_gecerli_o = yanit_gecerli_q;
  assign yanit_veri_o    = yanit_veri_q;
  assign adres_hatasi_o  = hata_q;

endmodule

// File: tb/tb_tek_port_ram_denetleyici.sv
// Directed bench: controller with 12 legal rows driving a behavioural single-port RAM.
module tb_tek_port_ram_denetleyici;

  localparam int SATIR = 12;

  typedef struct {
    logic        yaz;
    logic [3:0]  adres;
    logic [15:0] veri;
    logic        hata;
    logic [15:0] beklenen;
  } vektor_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        istek_gecerli = 1'b0;
  logic        istek_hazir;
  logic        istek_yaz = 1'b0;
  logic [3:0]  istek_adres = '0;
  logic [15:0] istek_veri = '0;
  logic        yanit_gecerli;
  logic [15:0] yanit_veri;
  logic        adres_hatasi;
  logic [3:0]  adres;
  wire  [15:0] veri;
  logic        cip_aktif;
  logic        bellege_yaz;
  logic        bellekten_oku;

  int n_kars = 0;
  int n_hata = 0;

  always #5 clk = ~clk;

  tek_port_ram_denetleyici #(
    .adres_genisligi(4),
    .veri_obegi(16),
    .satir_sayisi(SATIR)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .istek_gecerli_i(istek_gecerli),
    .istek_hazir_o(istek_hazir),
    .istek_yaz_i(istek_yaz),
    .istek_adres_i(istek_adres),
    .istek_veri_i(istek_veri),
    .yanit_gecerli_o(yanit_gecerli),
    .yanit_veri_o(yanit_veri),
    .adres_hatasi_o(adres_hatasi),
    .adres_o(adres),
    .veri_io(veri),
    .cip_aktif_o(cip_aktif),
    .bellege_yaz_o(bellege_yaz),
    .bellekten_oku_o(bellekten_oku)
  );

  // Behavioural RAM: registered output, drives the bus only under its output enable.
  logic [15:0] mem [16];
  logic [15:0] ram_q;
  always @(posedge clk) begin
    if (cip_aktif) begin
      if (bellege_yaz) mem[adres] <= veri;
      else             ram_q <= mem[adres];
    end
  end
  assign veri = (cip_aktif && bellekten_oku && !bellege_yaz) ? ram_q : 16'hzzzz;

  task automatic chk(input string ad, input logic [15:0] gercek, input logic [15:0] beklenen);
    n_kars++;
    if (gercek !== beklenen) begin
      n_hata++;
      $display("FAIL %s: actual %h required %h", ad, gercek, beklenen);
    end
  endtask

  function automatic vektor_t v(input logic yaz, input logic [3:0] a, input logic [15:0] d,
                                input logic h, input logic [15:0] b);
    vektor_t r;
    r.yaz = yaz; r.adres = a; r.veri = d; r.hata = h; r.beklenen = b;
    return r;
  endfunction

  task automatic sifir_sonrasi();
`ifdef RAM_TEMIZLE_EN
    #1 chk("sweep_hazir_ilk", {15'd0, istek_hazir}, 16'd0);
    for (int i = 0; i < SATIR; i++) begin
      @(negedge clk);
      chk("sweep_cip", {15'd0, cip_aktif}, 16'd1);
      chk("sweep_yaz", {15'd0, bellege_yaz}, 16'd1);
      chk("sweep_adres", {12'd0, adres}, 16'(i));
      chk("sweep_veri", veri, 16'h0000);
      chk("sweep_hazir", {15'd0, istek_hazir}, 16'd0);
    end
    @(negedge clk);
    chk("sweep_son_cip", {15'd0, cip_aktif}, 16'd0);
    chk("sweep_son_hazir", {15'd0, istek_hazir}, 16'd1);
`else
    #1 chk("hazir_rst_sonrasi", {15'd0, istek_hazir}, 16'd1);
`endif
  endtask

  // Starts at a point where the previous transaction has just returned to idle.
  task automatic islem(input vektor_t t);
    int bekle = 0;
    while (!istek_hazir && bekle < 50) begin
      @(negedge clk);
      bekle++;
    end
    chk("hazir_bekle", {15'd0, istek_hazir}, 16'd1);
    istek_gecerli = 1'b1;
    istek_yaz     = t.yaz;
    istek_adres   = t.adres;
    istek_veri    = t.veri;
    @(negedge clk);
    istek_gecerli = 1'b0;
    istek_yaz     = ~t.yaz;
    istek_adres   = ~t.adres;
    istek_veri    = ~t.veri;
    if (t.hata) begin
      chk("hata_pulse", {15'd0, adres_hatasi}, 16'd1);
      chk("hata_cip", {15'd0, cip_aktif}, 16'd0);
      chk("hata_yg", {15'd0, yanit_gecerli}, 16'd0);
      chk("hata_hazir", {15'd0, istek_hazir}, 16'd0);
      @(negedge clk);
      chk("hata_bitti", {15'd0, adres_hatasi}, 16'd0);
      chk("hata_yg2", {15'd0, yanit_gecerli}, 16'd0);
      chk("hata_hazir2", {15'd0, istek_hazir}, 16'd1);
    end else if (t.yaz) begin
      chk("yaz_cip", {15'd0, cip_aktif}, 16'd1);
      chk("yaz_strobe", {15'd0, bellege_yaz}, 16'd1);
      chk("yaz_oku", {15'd0, bellekten_oku}, 16'd0);
      chk("yaz_adres", {12'd0, adres}, {12'd0, t.adres});
      chk("yaz_veri", veri, t.veri);
      chk("yaz_hazir", {15'd0, istek_hazir}, 16'd0);
      @(negedge clk);
      chk("yaz_sonra_cip", {15'd0, cip_aktif}, 16'd0);
      chk("yaz_sonra_strobe", {15'd0, bellege_yaz}, 16'd0);
      chk("yaz_sonra_hazir", {15'd0, istek_hazir}, 16'd1);
    end else begin
      chk("oku1_cip", {15'd0, cip_aktif}, 16'd1);
      chk("oku1_yaz", {15'd0, bellege_yaz}, 16'd0);
      chk("oku1_oku", {15'd0, bellekten_oku}, 16'd0);
      chk("oku1_adres", {12'd0, adres}, {12'd0, t.adres});
      chk("oku1_yg", {15'd0, yanit_gecerli}, 16'd0);
      @(negedge clk);
      chk("oku2_cip", {15'd0, cip_aktif}, 16'd1);
      chk("oku2_oku", {15'd0, bellekten_oku}, 16'd1);
      chk("oku2_yaz", {15'd0, bellege_yaz}, 16'd0);
      chk("oku2_veri", veri, t.beklenen);
      chk("oku2_yg", {15'd0, yanit_gecerli}, 16'd0);
      @(negedge clk);
      chk("donus_yg", {15'd0, yanit_gecerli}, 16'd1);
      chk("donus_veri", yanit_veri, t.beklenen);
      chk("donus_cip", {15'd0, cip_aktif}, 16'd0);
      chk("donus_oku", {15'd0, bellekten_oku}, 16'd0);
      chk("donus_yaz", {15'd0, bellege_yaz}, 16'd0);
      chk("donus_hazir", {15'd0, istek_hazir}, 16'd0);
      @(negedge clk);
      chk("bos_yg", {15'd0, yanit_gecerli}, 16'd0);
      chk("bos_veri_tut", yanit_veri, t.beklenen);
      chk("bos_hazir", {15'd0, istek_hazir}, 16'd1);
    end
  endtask

  initial begin
    vektor_t tablo [16];
    tablo[0]  = v(1'b1, 4'd3,  16'hBEEF, 1'b0, 16'h0000);
    tablo[1]  = v(1'b0, 4'd3,  16'h0000, 1'b0, 16'hBEEF);
    tablo[2]  = v(1'b1, 4'd5,  16'h5555, 1'b0, 16'h0000);
    tablo[3]  = v(1'b1, 4'd9,  16'h9999, 1'b0, 16'h0000);
    tablo[4]  = v(1'b0, 4'd5,  16'h0000, 1'b0, 16'h5555);
    tablo[5]  = v(1'b1, 4'd5,  16'h1234, 1'b0, 16'h0000);
    tablo[6]  = v(1'b0, 4'd5,  16'h0000, 1'b0, 16'h1234);
    tablo[7]  = v(1'b0, 4'd14, 16'h0000, 1'b1, 16'h0000);
    tablo[8]  = v(1'b1, 4'd12, 16'hDEAD, 1'b1, 16'h0000);
    tablo[9]  = v(1'b1, 4'd11, 16'hCAFE, 1'b0, 16'h0000);
    tablo[10] = v(1'b0, 4'd11, 16'h0000, 1'b0, 16'hCAFE);
    tablo[11] = v(1'b0, 4'd12, 16'h0000, 1'b1, 16'h0000);
    tablo[12] = v(1'b1, 4'd15, 16'hF00D, 1'b1, 16'h0000);
    tablo[13] = v(1'b1, 4'd0,  16'h0001, 1'b0, 16'h0000);
    tablo[14] = v(1'b0, 4'd0,  16'h0000, 1'b0, 16'h0001);
    tablo[15] = v(1'b0, 4'd3,  16'h0000, 1'b0, 16'hBEEF);

    repeat (2) @(negedge clk);
    chk("rst_cip", {15'd0, cip_aktif}, 16'd0);
    chk("rst_yaz", {15'd0, bellege_yaz}, 16'd0);
    chk("rst_oku", {15'd0, bellekten_oku}, 16'd0);
    chk("rst_yg", {15'd0, yanit_gecerli}, 16'd0);
    chk("rst_hata", {15'd0, adres_hatasi}, 16'd0);
    chk("rst_hazir", {15'd0, istek_hazir}, 16'd0);
    chk("rst_adres", {12'd0, adres}, 16'd0);
    chk("rst_yanit_veri", yanit_veri, 16'd0);
    rst = 1'b0;
    sifir_sonrasi();

    for (int i = 0; i < 16; i++) islem(tablo[i]);

    // Reset in the middle of a read, while the RAM is driving the bus.
    chk("ara_hazir", {15'd0, istek_hazir}, 16'd1);
    istek_gecerli = 1'b1;
    istek_yaz     = 1'b0;
    istek_adres   = 4'd3;
    @(negedge clk);
    istek_gecerli = 1'b0;
    @(negedge clk);
    chk("ara_oku2", {15'd0, bellekten_oku}, 16'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("ara_cip", {15'd0, cip_aktif}, 16'd0);
    chk("ara_oku", {15'd0, bellekten_oku}, 16'd0);
    chk("ara_yaz", {15'd0, bellege_yaz}, 16'd0);
    chk("ara_yg", {15'd0, yanit_gecerli}, 16'd0);
    chk("ara_hata", {15'd0, adres_hatasi}, 16'd0);
    chk("ara_yanit_veri", yanit_veri, 16'd0);
    chk("ara_hazir_rst", {15'd0, istek_hazir}, 16'd0);
    rst = 1'b0;
    sifir_sonrasi();
    chk("ara_yg_sonra", {15'd0, yanit_gecerli}, 16'd0);
    @(negedge clk);
    chk("ara_yg_sonra2", {15'd0, yanit_gecerli}, 16'd0);

`ifdef RAM_TEMIZLE_EN
    islem(v(1'b0, 4'd9, 16'h0000, 1'b0, 16'h0000));
`else
    islem(v(1'b0, 4'd9, 16'h0000, 1'b0, 16'h9999));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_kars, n_hata);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual no finish required finish");
    $fatal(1, "bench timed out");
  end

endmodule

// File: doc/tek_port_ram_denetleyici.md
Name: tek_port_ram_denetleyici

Overview:
- Bus master for the team's single-port RAM; drives the RAM's address, shared tri-state data bus and chip, write and read strobes.
- Converts a user-side valid/ready request stream into correctly timed RAM bus cycles and returns read data with a one-cycle valid pulse.
- Owns bus turnaround so the controller and RAM never drive `veri` at the same time.
- Sits between the processing logic and the RAM instance.

Parameters:
- adres_genisligi, 4, RAM address width.
- veri_obegi, 16, data word width.
- satir_sayisi, 16, number of valid RAM rows; legal addresses are 0..satir_sayisi-1.

Ports:
- clk  in  1  single clock; everything on the rising edge.
- rst  in  1  synchronous reset, active-high.
- istek_gecerli  in  1  request valid.
- istek_hazir  out  1  controller can accept a request.
- istek_yaz  in  1  1 = write, 0 = read.
- istek_adres  in  adres_genisligi  request address.
- istek_veri  in  veri_obegi  write data.
- yanit_gecerli  out  1  one-cycle pulse: read data valid.
- yanit_veri  out  veri_obegi  read data, held until the next read completes.
- adres_hatasi  out  1  one-cycle pulse: request address >= satir_sayisi.
- adres  out  adres_genisligi  RAM address.
- veri  inout  veri_obegi  RAM data bus.
- cip_aktif  out  1  RAM chip enable.
- bellege_yaz  out  1  RAM write strobe.
- bellekten_oku  out  1  RAM output enable.

Behaviour:
- Reset values:
  - State BOS.
  - cip_aktif, bellege_yaz, bellekten_oku, yanit_gecerli, adres_hatasi, istek_hazir = 0.
  - adres = 0, yanit_veri = 0, veri driven hi-Z.
- Handshake:
  - A request is accepted on a rising edge where istek_gecerli & istek_hazir.
  - On acceptance, istek_yaz, istek_adres and istek_veri are registered; later input changes are ignored.
  - istek_hazir = 1 only in BOS and only when not in reset.
- Bus outputs are registered from the state; veri is driven only in YAZ.
- FSM states and transitions:
  - BOS: idle; all strobes 0; veri hi-Z.
    - Accepted write with legal address -> YAZ.
    - Accepted read with legal address -> OKU_1.
    - Illegal address -> HATA.
  - YAZ: cip_aktif=1, bellege_yaz=1, bellekten_oku=0; adres and veri driven from the latched values. The RAM commits at the end of the cycle. -> BOS.
  - OKU_1: cip_aktif=1, bellege_yaz=0, bellekten_oku=0; veri hi-Z. The RAM loads its output register at the end of the cycle. -> OKU_2.
  - OKU_2: cip_aktif=1, bellege_yaz=0, bellekten_oku=1; the RAM drives veri. yanit_veri captures veri at the end of the cycle. -> DONUS.
  - DONUS: all strobes 0; veri hi-Z; yanit_gecerli=1 for exactly this cycle; istek_hazir=0. This is the turnaround cycle. -> BOS.
  - HATA: no bus activity; adres_hatasi=1 for this cycle; no yanit_gecerli. -> BOS.
- Latency:
  - Write: committed in the cycle after acceptance; next acceptance possible 2 cycles after the previous one.
  - Read: yanit_gecerli high in the 3rd cycle after acceptance; read-to-next-acceptance is 4 cycles.
- Turnaround: the controller never drives veri in the cycle immediately after OKU_2, which guarantees one idle cycle before any write following a read.
- Address check: the comparison is unsigned and done at acceptance. When satir_sayisi = 2^adres_genisligi, HATA is unreachable.
- Reset mid-operation: at the next edge, return to BOS with reset values; the pending access is abandoned; no yanit_gecerli or adres_hatasi pulse; yanit_veri is cleared to 0.

Optional Feature:
- Macro: RAM_TEMIZLE_EN.
- Defined:
  - After rst deasserts, the FSM enters TEMIZLE instead of BOS.
  - TEMIZLE writes 0 to addresses 0..satir_sayisi-1, one per cycle: cip_aktif=1, bellege_yaz=1, veri=0, adres incrementing.
  - Sweep takes satir_sayisi cycles, then -> BOS.
  - istek_hazir=0 throughout the sweep.
  - rst during the sweep restarts it from address 0 once rst deasserts.
- Undefined: no TEMIZLE state; BOS on the first cycle after reset; RAM contents are unspecified until written.

Test Plan:
- Reset, then write addr 3 = 0xBEEF -> YAZ cycle on the edge after acceptance with adres=3, veri=0xBEEF, cip_aktif=1, bellege_yaz=1; istek_hazir back to 1 the cycle after.
- Read addr 3 after the previous write -> OKU_1, OKU_2, then yanit_gecerli=1 for one cycle with yanit_veri=0xBEEF; bellekten_oku high only in OKU_2.
- Read addr 5 immediately followed by write addr 5 = 0x1234 -> DONUS idle cycle with veri hi-Z between OKU_2 and YAZ; no X/contention on veri; a re-read returns 0x1234.
- satir_sayisi=12, request addr 14 -> adres_hatasi pulse 1 cycle, cip_aktif stays 0, no yanit_gecerli.
- Assert rst during OKU_2 -> next cycle all strobes 0, veri hi-Z, no yanit_gecerli, yanit_veri=0, istek_hazir=1 after rst drops.
- With RAM_TEMIZLE_EN, satir_sayisi=16 -> 16 write cycles on addrs 0..15 with veri=0, istek_hazir=0 throughout; a read of addr 9 afterwards returns 0.
